regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
- Initiator-side controller that drives the read and write ports of the 8x8 register file.
- Accepts one register-to-register operation per command over a valid/ready handshake.
- Per command: drives RX/RY, captures busX/busY, computes an 8-bit ALU result, then issues one write-back cycle (WEN/RW/busW).
- Sits between the instruction/test front-end and the register file; the only agent allowed to drive its ports.

Parameters:
DW, 8, data width of busX/busY/busW/cmd_imm/result
AW, 3, register index width (2^AW registers)

Ports:
Clk  input  1  clock, all state updates on posedge
Rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  operation code
cmd_rd  input  AW  destination register index
cmd_rs  input  AW  source register X index
cmd_rt  input  AW  source register Y index
cmd_imm  input  DW  immediate operand
RX  output  AW  read index to register file port X
RY  output  AW  read index to register file port Y
busX  input  DW  read data from port X (combinational in RX)
busY  input  DW  read data from port Y (combinational in RY)
WEN  output  1  write enable to register file
RW  output  AW  write index to register file
busW  output  DW  write data to register file
done  output  1  one-cycle pulse when a command retires
result  output  DW  result of last retired command, held until next retire

Behaviour:
- Reset (async, Rst=1):
  - state=IDLE; cmd_ready=1, RX=RY=RW=0, busW=0, WEN=0, done=0, result=0.
  - Latched command fields cleared. Reset mid-operation abandons the command with no write.
  - WEN drops immediately with Rst, not at the next edge.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE. All outputs registered.
- IDLE:
  - cmd_ready=1.
  - On posedge with cmd_valid=1: latch op/rd/rs/rt/imm; RX<=rs, RY<=rt; go READ.
  - cmd_valid=0: stay.
- READ: cmd_ready=0; RX/RY stable. On posedge capture opA<=busX, opB<=busY; go EXEC.
- EXEC: compute res (DW bits, wrap modulo 2^DW) from opA/opB/imm; on posedge busW<=res, RW<=rd, WEN<=(rd!=0); go WRITE.
- WRITE:
  - WEN/RW/busW held one cycle, so the register file samples them on the posedge leaving WRITE.
  - On that edge: WEN<=0, done<=1, result<=res, cmd_ready<=1; go IDLE.
  - done is high for exactly the first IDLE cycle.
- Throughput: one command per 4 cycles, measured accept edge to accept edge. A new command may be accepted in the same cycle done is high.
- Ops:
  - 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR.
  - 5 SLT: 1 if signed a<b else 0.
  - 6 ADDI a+imm.
  - 7 LI imm (RX/RY still driven, values ignored).
- rd=0: no write (WEN stays 0). done and result still update.
- Read-after-write: the next command's READ occurs after WRITE's posedge, so it sees updated register contents. No forwarding needed.
- cmd_* inputs are ignored outside IDLE. cmd_valid held high across a busy period is accepted only when back in IDLE.
- RX, RY, RW, busW hold their last values in IDLE (no glitching to 0).

Optional Feature:
- Macro REGSEQ_FLAGS_EN.
- Defined:
  - Adds outputs flag_z (1) and flag_c (1), reset 0, updated with result at retire.
  - flag_z = (res==0).
  - flag_c = carry out of bit DW-1 for ADD/ADDI, borrow for SUB, 0 for other ops.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then LI r1,8'h3C, LI r2,8'hC5 -> WEN pulses with RW=1 busW=3C, then RW=2 busW=C5; done pulses twice; each accept 4 cycles apart.
- ADD r3,r1,r2 after above -> RX=1, RY=2 during READ; busW=8'h01 to RW=3; result=01; flag_c=1, flag_z=0 if REGSEQ_FLAGS_EN.
- SLT r4,r2,r1 (C5 signed -59 < 3C) -> busW=8'h01; SUB r5,r1,r1 -> busW=00, flag_z=1.
- ADDI r0,r1,8'h10 -> WEN never asserted; done pulses; result=8'h4C.
- Rst pulse asserted during EXEC of ADD r6 -> WEN stays 0, cmd_ready=1 immediately, r6 unchanged (read back 00 via later ADD r7,r6,r0 -> busW=00).
- cmd_valid held high for 12 cycles with back-to-back commands -> exactly 3 accepts; cmd_ready high only in IDLE cycles; done and accept coincide.

Source files
------------

// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sequencer
// Brief    : Four-phase (IDLE/READ/EXEC/WRITE) controller driving an 8x8
//            register file; optional flag outputs via REGSEQ_FLAGS_EN.
// Revision : 1.0
// ============================================================================
module regfile_sequencer #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs,
    input  logic [AW-1:0] cmd_rt,
    input  logic [DW-1:0] cmd_imm,
    output logic [AW-1:0] RX,
    output logic [AW-1:0] RY,
    input  logic [DW-1:0] busX,
    input  logic [DW-1:0] busY,
    output logic          WEN,
    output logic [AW-1:0] RW,
    output logic [DW-1:0] busW,
    output logic          done,
`ifdef REGSEQ_FLAGS_EN
    output logic          flag_z,
    output logic          flag_c,
`endif
    output logic [DW-1:0] result
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLT  = 3'd5;
    localparam logic [2:0] OP_ADDI = 3'd6;
    localparam logic [2:0] OP_LI   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [AW-1:0] rx_q, rx_d, ry_q, ry_d, rw_q, rw_d;
    logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [DW-1:0] busw_q, busw_d, result_q, result_d;
    logic          wen_q, wen_d, done_q, done_d, ready_q, ready_d;
    logic [DW:0]   alu_wide;
    logic [DW-1:0] alu_res;

    // Operands stay latched through WRITE, so the ALU output is valid in both EXEC and WRITE.
    always_comb begin
        alu_wide = '0;
        case (op_q)
            OP_ADD:  alu_wide = {1'b0, opa_q} + {1'b0, opb_q};
            OP_SUB:  alu_wide = {1'b0, opa_q} - {1'b0, opb_q};
            OP_AND:  alu_wide = {1'b0, opa_q & opb_q};
            OP_OR:   alu_wide = {1'b0, opa_q | opb_q};
            OP_XOR:  alu_wide = {1'b0, opa_q ^ opb_q};
            OP_SLT:  alu_wide = {{DW{1'b0}}, ($signed(opa_q) < $signed(opb_q))};
            OP_ADDI: alu_wide = {1'b0, opa_q} + {1'b0, imm_q};
            OP_LI:   alu_wide = {1'b0, imm_q};
            default: alu_wide = '0;
        endcase
        alu_res = alu_wide[DW-1:0];
    end

`ifdef REGSEQ_FLAGS_EN
    logic flag_z_q, flag_z_d, flag_c_q, flag_c_d;
    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`else
    logic unused_carry;
    assign unused_carry = alu_wide[DW];
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        rw_d     = rw_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        busw_d   = busw_q;
        result_d = result_q;
        ready_d  = ready_q;
        wen_d    = 1'b0;
        done_d   = 1'b0;
`ifdef REGSEQ_FLAGS_EN
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    imm_d   = cmd_imm;
                    rx_d    = cmd_rs;
                    ry_d    = cmd_rt;
                    ready_d = 1'b0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                opa_d   = busX;
                opb_d   = busY;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                busw_d  = alu_res;
                rw_d    = rd_q;
                wen_d   = (rd_q != '0);
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                done_d   = 1'b1;
                result_d = alu_res;
                ready_d  = 1'b1;
`ifdef REGSEQ_FLAGS_EN
                flag_z_d = (alu_res == '0);
                flag_c_d = alu_wide[DW];
`endif
                state_d  = ST_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            rw_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            busw_q   <= '0;
            result_q <= '0;
            ready_q  <= 1'b1;
            wen_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef REGSEQ_FLAGS_EN
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            rw_q     <= rw_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            busw_q   <= busw_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            wen_q    <= wen_d;
            done_q   <= done_d;
`ifdef REGSEQ_FLAGS_EN
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
`endif
        end
    end

    assign cmd_ready = ready_q;
    assign RX        = rx_q;
    assign RY        = ry_q;
    assign RW        = rw_q;
    assign busW      = busw_q;
    assign WEN       = wen_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sequencer
// Brief    : Directed scoreboard bench for regfile_sequencer with a
//            behavioural 8x8 register file attached.
// Revision : 1.0
// ============================================================================
module tb_regfile_sequencer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0, cmd_rd = '0, cmd_rs = '0, cmd_rt = '0;
    logic [7:0] cmd_imm = '0;
    logic [2:0] RX, RY, RW;
    logic [7:0] busX, busY, busW, result;
    logic       WEN, done;
`ifdef REGSEQ_FLAGS_EN
    logic       flag_z, flag_c;
`endif

    regfile_sequencer #(.DW(8), .AW(3)) dut (
        .Clk(Clk), .Rst(Rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_imm(cmd_imm),
        .RX(RX), .RY(RY), .busX(busX), .busY(busY),
        .WEN(WEN), .RW(RW), .busW(busW),
        .done(done),
`ifdef REGSEQ_FLAGS_EN
        .flag_z(flag_z), .flag_c(flag_c),
`endif
        .result(result)
    );

    always #5 Clk = ~Clk;

    // Behavioural register file: combinational read, write on posedge.
    logic [7:0] rf [8];
    assign busX = rf[RX];
    assign busY = rf[RY];
    always @(posedge Clk) if (WEN) rf[RW] <= busW;

    typedef struct { logic [2:0] rw; logic [7:0] data; } wb_t;
    typedef struct { logic [7:0] res; logic z; logic c; } res_t;
    wb_t  wb_q [$];
    res_t res_q [$];
    logic [7:0] exp_rf [8];

    int vectors = 0, miscompares = 0;
    int cyc = 0, tracked = 0, done_cnt = 0, last_acc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    function automatic logic [8:0] model(input int op, input int a, input int b, input int imm);
        int r, sa, sb;
        logic c;
        c = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 255); end
            1: begin r = a - b; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                sa = (a > 127) ? a - 256 : a;
                sb = (b > 127) ? b - 256 : b;
                r  = (sa < sb) ? 1 : 0;
            end
            6: begin r = a + imm; c = (r > 255); end
            default: r = imm;
        endcase
        return {c, 8'(r & 255)};
    endfunction

    task automatic push_expect(input int op, input int rd, input int rs, input int rt, input int imm);
        logic [8:0] m;
        m = model(op, int'(exp_rf[rs]), int'(exp_rf[rt]), imm);
        if (rd != 0) begin
            wb_q.push_back('{rw: 3'(rd), data: m[7:0]});
            exp_rf[rd] = m[7:0];
        end
        res_q.push_back('{res: m[7:0], z: (m[7:0] == 8'h00), c: m[8]});
        tracked++;
    endtask

    task automatic drive(input int op, input int rd, input int rs, input int rt, input int imm);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_rd    = 3'(rd);
        cmd_rs    = 3'(rs);
        cmd_rt    = 3'(rt);
        cmd_imm   = 8'(imm);
    endtask

    task automatic send(input int op, input int rd, input int rs, input int rt, input int imm,
                        input bit track, input int gap);
        int n = 0;
        @(negedge Clk);
        while (!cmd_ready && n < 20) begin @(negedge Clk); n++; end
        if (!cmd_ready) timeout_fail("cmd_ready_wait");
        drive(op, rd, rs, rt, imm);
        if (track) push_expect(op, rd, rs, rt, imm);
        @(posedge Clk);
        #1;
        cmd_valid = 1'b0;
        if (gap != 0) check("accept_gap", 32'(cyc - last_acc), 32'(gap));
        last_acc = cyc;
        check("ready_in_read", cmd_ready, 0);
        check("rx_in_read", RX, rs);
        check("ry_in_read", RY, rt);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((res_q.size() != 0 || !cmd_ready) && n < 30) begin @(negedge Clk); n++; end
        if (n >= 30) timeout_fail("retire_wait");
    endtask

    // Monitor: every write-back and every retire is matched against the scoreboard.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (WEN) begin
                if (wb_q.size() == 0) check("unexpected_wen", WEN, 0);
                else begin
                    wb_t e;
                    e = wb_q.pop_front();
                    check("wb_rw", RW, e.rw);
                    check("wb_data", busW, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                if (res_q.size() == 0) check("unexpected_done", done, 0);
                else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("result", result, r.res);
`ifdef REGSEQ_FLAGS_EN
                    check("flag_z", flag_z, r.z);
                    check("flag_c", flag_c, r.c);
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int k, prev;
        for (int i = 0; i < 8; i++) begin
            rf[i]     <= 8'h00;
            exp_rf[i]  = 8'h00;
        end
        repeat (3) @(negedge Clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_wen", WEN, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_rx", RX, 0);
        check("rst_ry", RY, 0);
        check("rst_rw", RW, 0);
        check("rst_busw", busW, 0);
`ifdef REGSEQ_FLAGS_EN
        check("rst_flag_z", flag_z, 0);
        check("rst_flag_c", flag_c, 0);
`endif
        @(posedge Clk);
        #2 Rst = 1'b0;

        send(7, 1, 0, 0, 8'h3C, 1, 0);
        send(7, 2, 0, 0, 8'hC5, 1, 4);
        send(0, 3, 1, 2, 0, 1, 4);
        wait_idle();
        check("add_result", result, 8'h01);
        check("hold_rx", RX, 1);
        check("hold_ry", RY, 2);
        check("hold_rw", RW, 3);
        check("hold_busw", busW, 8'h01);
        send(5, 4, 2, 1, 0, 1, 0);
        send(1, 5, 1, 1, 0, 1, 4);
        send(6, 0, 1, 0, 8'h10, 1, 4);
        wait_idle();
        check("addi_r0_result", result, 8'h4C);

        // Abandon ADD r6 in EXEC: no write, no retire.
        send(0, 6, 1, 2, 0, 0, 0);
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("abort_wen", WEN, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        @(posedge Clk);
        #2 Rst = 1'b0;
        repeat (2) @(negedge Clk);
        check("abort_no_write_r6", rf[6], 8'h00);
        send(0, 7, 6, 0, 0, 1, 0);
        wait_idle();
        check("r7_result", result, 8'h00);

        // cmd_valid held for 12 cycles with a fresh command each time the sequencer is idle.
        k = 0;
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (cmd_ready) begin
                if (k > 0) begin
                    check("stream_done_with_accept", done, 1);
                    check("stream_gap", 32'(i - prev), 4);
                end
                case (k)
                    0: begin drive(4, 6, 1, 2, 0); push_expect(4, 6, 1, 2, 0); end
                    1: begin drive(3, 7, 1, 2, 0); push_expect(3, 7, 1, 2, 0); end
                    default: begin drive(2, 6, 6, 7, 0); push_expect(2, 6, 6, 7, 0); end
                endcase
                prev = i;
                k++;
            end
        end
        @(negedge Clk);
        cmd_valid = 1'b0;
        check("stream_accepts", 32'(k), 3);
        wait_idle();
        check("wb_queue_empty", 32'(wb_q.size()), 0);
        check("done_count", 32'(done_cnt), 32'(tracked));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
